// File: rtl/nonce_sched_if.sv
// nonce_sched_if: bundle of every non-clock signal of the nonce scheduler.
//   job_*   : job request handshake (environment -> scheduler)
//   abort   : stop the current job
//   hash_*  : nonce issue into the Blake2b pipeline, with back-pressure
//   cmp_*   : target/valid out to the comparator, hit and nonce back
//   busy    : job in progress
//   res_*   : result handshake (scheduler -> environment)
// Modports: slave = scheduler side, master = environment side.
interface nonce_sched_if;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_nonce_start;
  logic [31:0] job_nonce_end;
  logic [63:0] job_target;
  logic        abort;
  logic        hash_stall;
  logic        hash_issue;
  logic [63:0] hash_m04;
  logic        cmp_valid;
  logic [63:0] cmp_target;
  logic        cmp_found;
  logic [31:0] cmp_nonce;
  logic        busy;
  logic        res_valid;
  logic        res_found;
  logic        res_aborted;
  logic [31:0] res_nonce;
  logic        res_ready;

  modport slave (
    input  job_valid, job_nonce_start, job_nonce_end, job_target, abort,
           hash_stall, cmp_found, cmp_nonce, res_ready,
    output job_ready, hash_issue, hash_m04, cmp_valid, cmp_target, busy,
           res_valid, res_found, res_aborted, res_nonce
  );

  modport master (
    output job_valid, job_nonce_start, job_nonce_end, job_target, abort,
           hash_stall, cmp_found, cmp_nonce, res_ready,
    input  job_ready, hash_issue, hash_m04, cmp_valid, cmp_target, busy,
           res_valid, res_found, res_aborted, res_nonce
  );
endinterface

// File: rtl/nonce_sched.sv
// nonce_sched: job-level controller for the Blake2b nonce search.
// Accepts a nonce range plus target, issues one nonce per cycle into the
// hash pipeline, stops on first hit / range end / abort, drains in-flight
// hashes so no stale hit reaches the next job, then presents the result.
// Ports:
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : nonce_sched_if.slave (job, hash, comparator and result signals)
// Parameters:
//   PIPE_LAT : cycles from hash_issue to result valid at the comparator
//   DRAIN_W  : drain counter width, must hold PIPE_LAT+2
module nonce_sched #(
  parameter int PIPE_LAT = 96,
  parameter int DRAIN_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  nonce_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} state_t;

  // Pipeline latency plus the comparator register plus one guard cycle.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT + 2);

  state_t               state_q, state_d;
  logic [31:0]          nonce_q, nonce_d;
  logic [31:0]          end_q, end_d;
  logic [63:0]          target_q, target_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 found_q, found_d;
  logic                 aborted_q, aborted_d;
  logic [31:0]          rnonce_q, rnonce_d;
  logic                 issue;

  // A hit or an abort suppresses the issue in the same cycle.
  assign issue = (state_q == ISSUE) & ~bus.hash_stall & ~bus.abort & ~bus.cmp_found;

  // NOTE: every register, including the datapath ones, is cleared by rst so
  // a reset mid-job leaves no stale target or result visible on the outputs.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from the values computed in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      nonce_q   <= '0;
      end_q     <= '0;
      target_q  <= '0;
      drain_q   <= '0;
      found_q   <= 1'b0;
      aborted_q <= 1'b0;
      rnonce_q  <= '0;
    end else begin
      state_q   <= state_d;
      nonce_q   <= nonce_d;
      end_q     <= end_d;
      target_q  <= target_d;
      drain_q   <= drain_d;
      found_q   <= found_d;
      aborted_q <= aborted_d;
      rnonce_q  <= rnonce_d;
    end
  end

  // NOTE: every signal written here gets a hold default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    nonce_d   = nonce_q;
    end_d     = end_q;
    target_d  = target_q;
    drain_d   = drain_q;
    found_d   = found_q;
    aborted_d = aborted_q;
    rnonce_d  = rnonce_q;

    unique case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          nonce_d   = bus.job_nonce_start;
          end_d     = bus.job_nonce_end;
          target_d  = bus.job_target;
          found_d   = 1'b0;
          aborted_d = 1'b0;
          rnonce_d  = '0;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.cmp_found || bus.abort) begin
          // A simultaneous hit and abort records both.
          if (bus.cmp_found) begin
            found_d  = 1'b1;
            rnonce_d = bus.cmp_nonce;
          end
          if (bus.abort) aborted_d = 1'b1;
          drain_d = DRAIN_LOAD;
          state_d = DRAIN;
        end else if (issue) begin
          nonce_d = nonce_q + 32'd1;  // wraps, so start > end is a wrapping range
          if (nonce_q == end_q) begin
            drain_d = DRAIN_LOAD;
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        drain_d = drain_q - DRAIN_W'(1);
        // First hit wins; hits from later in-flight nonces are discarded.
        if (bus.cmp_found && !found_q) begin
          found_d  = 1'b1;
          rnonce_d = bus.cmp_nonce;
        end
        if (bus.abort) aborted_d = 1'b1;
        if (drain_q <= DRAIN_W'(1)) state_d = REPORT;
      end

      REPORT: begin
        if (bus.res_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.job_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q == ISSUE) | (state_q == DRAIN);
  assign bus.cmp_valid   = (state_q == ISSUE) | (state_q == DRAIN);
  assign bus.cmp_target  = target_q;
  assign bus.hash_issue  = issue;
  assign bus.hash_m04    = {32'h0, nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
  assign bus.res_valid   = (state_q == REPORT);
  assign bus.res_found   = found_q;
  assign bus.res_aborted = aborted_q;
  assign bus.res_nonce   = rnonce_q;

endmodule

// File: tb/tb_nonce_sched.sv
// tb_nonce_sched: directed self-checking bench for nonce_sched.
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// well away from the rising (active) edge.
module tb_nonce_sched;
  localparam int PIPE_LAT = 96;
  localparam int DRAIN_N  = PIPE_LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  int   n;

  always #5 clk = ~clk;

  nonce_sched_if bus ();

  nonce_sched #(.PIPE_LAT(PIPE_LAT), .DRAIN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to the next sample point (1 ns after the falling edge).
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Present a job for one cycle; returns at the sample point of cycle T+1.
  task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t);
    @(negedge clk);
    bus.job_valid       = 1'b1;
    bus.job_nonce_start = s;
    bus.job_nonce_end   = e;
    bus.job_target      = t;
    #1;
    check("job_ready_idle", bus.job_ready, 1'b1);
    @(negedge clk);
    bus.job_valid = 1'b0;
    #1;
  endtask

  // Count cycles from the current sample until res_valid, with a bound.
  task automatic wait_report(output int cnt);
    cnt = 0;
    while (bus.res_valid !== 1'b1 && cnt < 300) begin
      cnt++;
      next_cycle();
    end
  endtask

  // Consume the result; returns at the first IDLE sample point.
  task automatic release_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    check("release_job_ready", bus.job_ready, 1'b1);
    check("release_res_valid", bus.res_valid, 1'b0);
  endtask

  initial begin
    bus.job_valid = 0; bus.job_nonce_start = 0; bus.job_nonce_end = 0;
    bus.job_target = 0; bus.abort = 0; bus.hash_stall = 0;
    bus.cmp_found = 0; bus.cmp_nonce = 0; bus.res_ready = 0;

    // Reset values.
    #12;
    check("rst_job_ready", bus.job_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cmp_valid", bus.cmp_valid, 1'b0);
    check("rst_hash_issue", bus.hash_issue, 1'b0);
    check("rst_hash_m04", bus.hash_m04, 64'h0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_nonce", bus.res_nonce, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: range 0x10..0x13, no hit, no stall.
    start_job(32'h10, 32'h13, 64'hDEAD_BEEF_0000_1111);
    check("t1_issue0", bus.hash_issue, 1'b1);
    check("t1_m04_0", bus.hash_m04, 64'h0000_0000_1000_0000);
    check("t1_cmp_valid", bus.cmp_valid, 1'b1);
    check("t1_cmp_target", bus.cmp_target, 64'hDEAD_BEEF_0000_1111);
    next_cycle();
    check("t1_issue1", bus.hash_issue, 1'b1);
    check("t1_m04_1", bus.hash_m04, 64'h0000_0000_1100_0000);
    next_cycle();
    check("t1_issue2", bus.hash_issue, 1'b1);
    check("t1_m04_2", bus.hash_m04, 64'h0000_0000_1200_0000);
    next_cycle();
    check("t1_issue3", bus.hash_issue, 1'b1);
    check("t1_m04_3", bus.hash_m04, 64'h0000_0000_1300_0000);
    next_cycle();
    check("t1_no_issue", bus.hash_issue, 1'b0);
    check("t1_busy_drain", bus.busy, 1'b1);
    wait_report(n);
    check("t1_drain_len", n, DRAIN_N);
    check("t1_found", bus.res_found, 1'b0);
    check("t1_aborted", bus.res_aborted, 1'b0);
    check("t1_nonce", bus.res_nonce, 32'h0);
    check("t1_busy_report", bus.busy, 1'b0);
    release_result();

    // 2: hit mid-ISSUE, later hit in DRAIN ignored.
    start_job(32'h100, 32'h1FF, 64'h0123_4567_89AB_CDEF);
    check("t2_issue0", bus.hash_issue, 1'b1);
    next_cycle();
    check("t2_issue1", bus.hash_issue, 1'b1);
    @(negedge clk);
    bus.cmp_found = 1'b1; bus.cmp_nonce = 32'h1234;
    #1;
    check("t2_hit_no_issue", bus.hash_issue, 1'b0);
    @(negedge clk);
    bus.cmp_found = 1'b0;
    #1;
    check("t2_drain_no_issue", bus.hash_issue, 1'b0);
    check("t2_drain_busy", bus.busy, 1'b1);
    @(negedge clk);
    bus.cmp_found = 1'b1; bus.cmp_nonce = 32'h5678;
    #1;
    @(negedge clk);
    bus.cmp_found = 1'b0;
    #1;
    check("t2_target_held", bus.cmp_target, 64'h0123_4567_89AB_CDEF);
    wait_report(n);
    check("t2_drain_len", n, DRAIN_N - 2);
    check("t2_found", bus.res_found, 1'b1);
    check("t2_nonce", bus.res_nonce, 32'h1234);
    check("t2_aborted", bus.res_aborted, 1'b0);
    release_result();

    // 3: wrapping range 0xFFFFFFFE..0x1.
    start_job(32'hFFFF_FFFE, 32'h1, 64'h1);
    check("t3_issue0", bus.hash_issue, 1'b1);
    check("t3_m04_0", bus.hash_m04, 64'h0000_0000_FEFF_FFFF);
    next_cycle();
    check("t3_issue1", bus.hash_issue, 1'b1);
    check("t3_m04_1", bus.hash_m04, 64'h0000_0000_FFFF_FFFF);
    next_cycle();
    check("t3_issue2", bus.hash_issue, 1'b1);
    check("t3_m04_2", bus.hash_m04, 64'h0);
    next_cycle();
    check("t3_issue3", bus.hash_issue, 1'b1);
    check("t3_m04_3", bus.hash_m04, 64'h0000_0000_0100_0000);
    next_cycle();
    check("t3_no_issue", bus.hash_issue, 1'b0);
    wait_report(n);
    check("t3_drain_len", n, DRAIN_N);
    check("t3_found_cleared", bus.res_found, 1'b0);
    check("t3_nonce_cleared", bus.res_nonce, 32'h0);
    release_result();

    // 4: stall for 3 cycles in a 3-nonce range.
    start_job(32'h20, 32'h22, 64'h2);
    check("t4_issue0", bus.hash_issue, 1'b1);
    check("t4_m04_0", bus.hash_m04, 64'h0000_0000_2000_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.hash_stall = 1'b1;
      #1;
      check("t4_stall_no_issue", bus.hash_issue, 1'b0);
      check("t4_stall_held", bus.hash_m04, 64'h0000_0000_2100_0000);
    end
    @(negedge clk);
    bus.hash_stall = 1'b0;
    #1;
    check("t4_issue1", bus.hash_issue, 1'b1);
    check("t4_m04_1", bus.hash_m04, 64'h0000_0000_2100_0000);
    next_cycle();
    check("t4_issue2", bus.hash_issue, 1'b1);
    check("t4_m04_2", bus.hash_m04, 64'h0000_0000_2200_0000);
    next_cycle();
    check("t4_no_issue", bus.hash_issue, 1'b0);
    wait_report(n);
    check("t4_drain_len", n, DRAIN_N);
    release_result();

    // 5: abort in ISSUE, full drain, result held while res_ready low.
    start_job(32'h40, 32'h4F, 64'h5);
    check("t5_issue0", bus.hash_issue, 1'b1);
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    check("t5_abort_no_issue", bus.hash_issue, 1'b0);
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    check("t5_drain_no_issue", bus.hash_issue, 1'b0);
    wait_report(n);
    check("t5_drain_len", n, DRAIN_N);
    check("t5_aborted", bus.res_aborted, 1'b1);
    check("t5_found", bus.res_found, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.cmp_found = (i == 2);  // ignored in REPORT
      bus.cmp_nonce = 32'h999;
      #1;
      check("t5_hold_valid", bus.res_valid, 1'b1);
      check("t5_hold_aborted", bus.res_aborted, 1'b1);
      check("t5_hold_found", bus.res_found, 1'b0);
      check("t5_hold_nonce", bus.res_nonce, 32'h0);
      check("t5_hold_job_ready", bus.job_ready, 1'b0);
    end
    bus.cmp_found = 1'b0;
    release_result();

    // 6: reset mid-DRAIN, then a normal job.
    start_job(32'h60, 32'h60, 64'h6666);
    check("t6_issue0", bus.hash_issue, 1'b1);
    check("t6_m04_0", bus.hash_m04, 64'h0000_0000_6000_0000);
    next_cycle();
    check("t6_single_no_issue", bus.hash_issue, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    check("t6_rst_job_ready", bus.job_ready, 1'b1);
    check("t6_rst_busy", bus.busy, 1'b0);
    check("t6_rst_cmp_valid", bus.cmp_valid, 1'b0);
    check("t6_rst_cmp_target", bus.cmp_target, 64'h0);
    check("t6_rst_m04", bus.hash_m04, 64'h0);
    check("t6_rst_res_valid", bus.res_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    start_job(32'h70, 32'h71, 64'h7);
    check("t6b_issue0", bus.hash_issue, 1'b1);
    check("t6b_m04_0", bus.hash_m04, 64'h0000_0000_7000_0000);
    next_cycle();
    check("t6b_issue1", bus.hash_issue, 1'b1);
    check("t6b_m04_1", bus.hash_m04, 64'h0000_0000_7100_0000);
    next_cycle();
    check("t6b_no_issue", bus.hash_issue, 1'b0);
    wait_report(n);
    check("t6b_drain_len", n, DRAIN_N);
    check("t6b_found", bus.res_found, 1'b0);
    release_result();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
